// File: rtl/ps2_key_decoder_fifo.sv
`default_nettype none
// ============================================================================
// Module  : ps2_key_decoder_fifo
// Brief   : PS/2 Set-2 scan decoder (E0/F0 prefixes, Shift, repeat filter)
//           that translates key presses to ASCII and queues them in a FIFO.
// Revision: 1.0 - initial release
// ============================================================================
module ps2_key_decoder_fifo #(
    parameter int FIFO_AW       = 2,
    parameter int EXT_STRICT    = 1,
    parameter int REPEAT_FILTER = 1,
    parameter int CASE_MODE     = 0,
    parameter int DROP_UNKNOWN  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] scan_byte,
    input  logic       rd_tick,
    input  logic       clr_ovf,
    output logic [7:0] ascii_code,
    output logic       empty,
    output logic       full,
    output logic       overflow,
    output logic       shift_held
);

    localparam int               DEPTH    = 2 ** FIFO_AW;
    localparam logic [7:0]       C_EXT    = 8'hE0;
    localparam logic [7:0]       C_BRK    = 8'hF0;
    localparam logic [7:0]       C_LSHIFT = 8'h12;
    localparam logic [7:0]       C_RSHIFT = 8'h59;
    localparam logic [FIFO_AW:0] PTR_ONE  = {{FIFO_AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               lshift_q, lshift_d;
    logic               rshift_q, rshift_d;
    logic               held_valid_q, held_valid_d;
    logic [8:0]         held_key_q, held_key_d;
    logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         mem_q [DEPTH];

    logic               cur_ext;
    logic               ev_make;
    logic               ev_break;
    logic [8:0]         key_id;
    logic               map_hit;
    logic               map_letter;
    logic [7:0]         map_val;
    logic               push_req;
    logic               do_push;
    logic               do_pop;
    logic               empty_w;
    logic               full_w;

    assign cur_ext    = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    assign key_id     = {cur_ext, scan_byte};
    assign shift_held = lshift_q | rshift_q;

    // Prefix tracking FSM: only final bytes of a sequence raise make/break events.
    always_comb begin
        state_d  = state_q;
        ev_make  = 1'b0;
        ev_break = 1'b0;
        if (rx_done_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_byte == C_EXT)      state_d = ST_EXT;
                    else if (scan_byte == C_BRK) state_d = ST_BRK;
                    else                         ev_make = 1'b1;
                end
                ST_EXT: begin
                    if (scan_byte == C_BRK)      state_d = ST_EXT_BRK;
                    else if (scan_byte == C_EXT) state_d = ST_EXT;
                    else begin
                        ev_make = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    ev_break = 1'b1;
                    state_d  = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        map_hit    = 1'b0;
        map_letter = 1'b0;
        map_val    = 8'h00;
        case (scan_byte)
            8'h05: begin map_hit = 1'b1; map_val = 8'h21; end
            8'h06: begin map_hit = 1'b1; map_val = 8'h22; end
            8'h1C: begin map_hit = 1'b1; map_letter = 1'b1; map_val = 8'h41; end
            8'h23: begin map_hit = 1'b1; map_letter = 1'b1; map_val = 8'h44; end
            8'h2B: begin map_hit = 1'b1; map_letter = 1'b1; map_val = 8'h46; end
            8'h33: begin map_hit = 1'b1; map_letter = 1'b1; map_val = 8'h48; end
            8'h3A: begin map_hit = 1'b1; map_letter = 1'b1; map_val = 8'h4D; end
            8'h2D: begin map_hit = 1'b1; map_letter = 1'b1; map_val = 8'h52; end
            8'h1B: begin map_hit = 1'b1; map_letter = 1'b1; map_val = 8'h53; end
            8'h2C: begin map_hit = 1'b1; map_letter = 1'b1; map_val = 8'h54; end
            8'h72: begin map_hit = (EXT_STRICT == 0) || cur_ext; map_val = 8'h35; end
            8'h6B: begin map_hit = (EXT_STRICT == 0) || cur_ext; map_val = 8'h34; end
            8'h74: begin map_hit = (EXT_STRICT == 0) || cur_ext; map_val = 8'h36; end
            8'h75: begin map_hit = (EXT_STRICT == 0) || cur_ext; map_val = 8'h38; end
            8'h5A: begin map_hit = 1'b1; map_val = 8'h0D; end
            default: begin map_hit = 1'b0; map_val = 8'h00; end
        endcase
        if (!map_hit) begin
            map_val = 8'h00;
        end else if (map_letter && (CASE_MODE != 0) && !shift_held) begin
            map_val = map_val + 8'h20;
        end
    end

    // Shift flags and held-key bookkeeping; held_key never tracks Shift keys.
    always_comb begin
        lshift_d     = lshift_q;
        rshift_d     = rshift_q;
        held_valid_d = held_valid_q;
        held_key_d   = held_key_q;
        push_req     = 1'b0;
        if (ev_make) begin
            if (scan_byte == C_LSHIFT) begin
                lshift_d = 1'b1;
            end else if (scan_byte == C_RSHIFT) begin
                rshift_d = 1'b1;
            end else begin
                held_valid_d = 1'b1;
                held_key_d   = key_id;
                if (!((REPEAT_FILTER != 0) && held_valid_q && (held_key_q == key_id))) begin
                    push_req = map_hit || (DROP_UNKNOWN == 0);
                end
            end
        end
        if (ev_break) begin
            if (scan_byte == C_LSHIFT) lshift_d = 1'b0;
            if (scan_byte == C_RSHIFT) rshift_d = 1'b0;
            if (held_valid_q && (held_key_q == key_id)) held_valid_d = 1'b0;
        end
    end

    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                     (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);

    // A pop frees the slot the same cycle, so a push while full is accepted then.
    always_comb begin
        do_pop     = rd_tick && !empty_w;
        do_push    = push_req && (!full_w || do_pop);
        wr_ptr_d   = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d   = do_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        overflow_d = overflow_q;
        if (clr_ovf) overflow_d = 1'b0;
        if (push_req && full_w && !do_pop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            lshift_q     <= 1'b0;
            rshift_q     <= 1'b0;
            held_valid_q <= 1'b0;
            held_key_q   <= 9'h000;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lshift_q     <= lshift_d;
            rshift_q     <= rshift_d;
            held_valid_q <= held_valid_d;
            held_key_q   <= held_key_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[FIFO_AW-1:0]] <= map_val;
        end
    end

    assign ascii_code = empty_w ? 8'h00 : mem_q[rd_ptr_q[FIFO_AW-1:0]];
    assign empty      = empty_w;
    assign full       = full_w;
    assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_ps2_key_decoder_fifo
// Brief   : Scoreboard bench for ps2_key_decoder_fifo (default and lowercase).
// Revision: 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder_fifo;

    logic       clk;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] scan_byte;
    logic       rd_tick;
    logic       clr_ovf;
    logic [7:0] ascii_code, ascii_lc;
    logic       empty, empty_lc;
    logic       full, full_lc;
    logic       overflow, overflow_lc;
    logic       shift_held, shift_lc;

    int         n_checks;
    int         n_fail;
    logic [7:0] exp_q[$];

    ps2_key_decoder_fifo u_dut (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .scan_byte(scan_byte),
        .rd_tick(rd_tick), .clr_ovf(clr_ovf), .ascii_code(ascii_code), .empty(empty),
        .full(full), .overflow(overflow), .shift_held(shift_held)
    );

    ps2_key_decoder_fifo #(.CASE_MODE(1)) u_dut_lc (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .scan_byte(scan_byte),
        .rd_tick(rd_tick), .clr_ovf(clr_ovf), .ascii_code(ascii_lc), .empty(empty_lc),
        .full(full_lc), .overflow(overflow_lc), .shift_held(shift_lc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic send(input logic [7:0] b, input logic rd);
        scan_byte    = b;
        rx_done_tick = 1'b1;
        rd_tick      = rd;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
        rd_tick      = 1'b0;
    endtask

    // Pops the scoreboard against the selected DUT, then checks it ends empty.
    task automatic drain(input logic lc, input string name);
        logic [7:0] exp;
        logic [7:0] act;
        logic       emp;
        while (exp_q.size() > 0) begin
            emp = lc ? empty_lc : empty;
            act = lc ? ascii_lc : ascii_code;
            exp = exp_q.pop_front();
            n_checks++;
            if (emp !== 1'b0) begin
                $display("FAIL %s_underrun: empty=%b, required 0 with head %h pending", name, emp, exp);
                n_fail++;
                exp_q.delete();
            end else begin
                n_checks++;
                if (act !== exp) begin
                    $display("FAIL %s_data: ascii_code=%h, required %h", name, act, exp);
                    n_fail++;
                end
                rd_tick = 1'b1;
                @(posedge clk);
                #1;
                rd_tick = 1'b0;
            end
        end
        emp = lc ? empty_lc : empty;
        act = lc ? ascii_lc : ascii_code;
        n_checks++;
        if (emp !== 1'b1 || act !== 8'h00) begin
            $display("FAIL %s_leftover: empty=%b ascii_code=%h, required empty=1 ascii_code=00", name, emp, act);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({empty, full, overflow, shift_held, ascii_code} !== {4'b1000, 8'h00}) begin
            $display("FAIL reset_state: e/f/o/s=%b%b%b%b ascii=%h, required 1000 ascii=00",
                     empty, full, overflow, shift_held, ascii_code);
            n_fail++;
        end
        rd_tick = 1'b1;
        @(posedge clk);
        #1;
        rd_tick = 1'b0;
        n_checks++;
        if (empty !== 1'b1 || ascii_code !== 8'h00) begin
            $display("FAIL rd_on_empty: empty=%b ascii=%h, required 1 00", empty, ascii_code);
            n_fail++;
        end
    endtask

    task automatic test_basic();
        do_reset();
        send(8'h1C, 1'b0); exp_q.push_back(8'h41);
        n_checks++;
        if (empty !== 1'b0 || ascii_code !== 8'h41) begin
            $display("FAIL basic_latency: empty=%b ascii=%h, required 0 41", empty, ascii_code);
            n_fail++;
        end
        drain(1'b0, "basic");
        // push and pop together on an empty FIFO: only the push happens
        send(8'h05, 1'b1); exp_q.push_back(8'h21);
        drain(1'b0, "push_pop_empty");
    endtask

    task automatic test_case();
        do_reset();
        send(8'h12, 1'b0);
        n_checks++;
        if (shift_lc !== 1'b1) begin
            $display("FAIL case_shift_set: shift_held=%b, required 1", shift_lc);
            n_fail++;
        end
        send(8'h1C, 1'b0); exp_q.push_back(8'h41);
        send(8'hF0, 1'b0); send(8'h1C, 1'b0);
        send(8'hF0, 1'b0); send(8'h12, 1'b0);
        n_checks++;
        if (shift_lc !== 1'b0) begin
            $display("FAIL case_shift_clr: shift_held=%b, required 0", shift_lc);
            n_fail++;
        end
        send(8'h1C, 1'b0); exp_q.push_back(8'h61);
        drain(1'b1, "case");
    endtask

    task automatic test_ext();
        do_reset();
        send(8'hE0, 1'b0); send(8'h75, 1'b0); exp_q.push_back(8'h38);
        send(8'h75, 1'b0);
        send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h75, 1'b0);
        send(8'h1C, 1'b0); exp_q.push_back(8'h41);
        send(8'h15, 1'b0);
        send(8'hE0, 1'b0); send(8'h5A, 1'b0); exp_q.push_back(8'h0D);
        send(8'h5A, 1'b0); exp_q.push_back(8'h0D);
        drain(1'b0, "ext");
    endtask

    task automatic test_repeat();
        do_reset();
        send(8'h23, 1'b0); exp_q.push_back(8'h44);
        send(8'h23, 1'b0);
        send(8'h23, 1'b0);
        send(8'hF0, 1'b0); send(8'h23, 1'b0);
        send(8'h23, 1'b0); exp_q.push_back(8'h44);
        drain(1'b0, "repeat");
    endtask

    task automatic test_overflow();
        logic [7:0] tbl [5];
        logic [7:0] asc [5];
        tbl = '{8'h1C, 8'h23, 8'h2B, 8'h33, 8'h3A};
        asc = '{8'h41, 8'h44, 8'h46, 8'h48, 8'h4D};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(tbl[i], 1'b0);
            exp_q.push_back(asc[i]);
        end
        n_checks++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
            $display("FAIL ovf_full4: full=%b overflow=%b, required 1 0", full, overflow);
            n_fail++;
        end
        send(tbl[4], 1'b0);
        n_checks++;
        if (full !== 1'b1 || overflow !== 1'b1 || ascii_code !== 8'h41) begin
            $display("FAIL ovf_set: full=%b overflow=%b ascii=%h, required 1 1 41", full, overflow, ascii_code);
            n_fail++;
        end
        void'(exp_q.pop_front());
        send(8'h2D, 1'b1); exp_q.push_back(8'h52);
        n_checks++;
        if (full !== 1'b1 || overflow !== 1'b1 || ascii_code !== 8'h44) begin
            $display("FAIL ovf_pushpop_full: full=%b overflow=%b ascii=%h, required 1 1 44", full, overflow, ascii_code);
            n_fail++;
        end
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
        n_checks++;
        if (overflow !== 1'b0) begin
            $display("FAIL ovf_clear: overflow=%b, required 0", overflow);
            n_fail++;
        end
        drain(1'b0, "ovf");
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(8'h12, 1'b0); send(8'h1C, 1'b0);
        send(8'hE0, 1'b0); send(8'hF0, 1'b0);
        do_reset();
        n_checks++;
        if (shift_held !== 1'b0 || empty !== 1'b1) begin
            $display("FAIL mid_reset_state: shift_held=%b empty=%b, required 0 1", shift_held, empty);
            n_fail++;
        end
        send(8'h5A, 1'b0); exp_q.push_back(8'h0D);
        drain(1'b0, "mid_reset");
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b1;
        rx_done_tick = 1'b0;
        scan_byte    = 8'h00;
        rd_tick      = 1'b0;
        clr_ovf      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_case();
        test_ext();
        test_repeat();
        test_overflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
